// File: rtl/wb_stage.sv
// Write-back stage: commits ALU/link results in one cycle and waits for load data,
// extracting and extending sub-word loads before the register-file write.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        pending_valid,
    output logic [4:0]  pending_rd,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic        reg_wr_out_q, reg_wr_out_d;
    logic        load_err_q, load_err_d;
    logic        pending_valid_q, pending_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept_s;
    logic        will_write_s;

    // Misaligned or unsupported load encodings are rejected before any memory wait.
    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lo[0];
            3'b010:         bad = (lo != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lo);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[8*lo +: 8];
        half_v = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b100:  res = {24'h000000, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b101:  res = {16'h0000, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    assign accept_s     = in_valid && in_ready_q;
    assign will_write_s = in_reg_write && (in_rd != 5'd0);

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        reg_write_d     = reg_write_q;
        rd_d            = rd_q;
        wb_sel_d        = wb_sel_q;
        funct3_d        = funct3_q;
        addr_lo_d       = addr_lo_q;
        alu_result_d    = alu_result_q;
        pc_plus4_d      = pc_plus4_q;
        write_reg_d     = write_reg_q;
        write_data_d    = write_data_q;
        reg_wr_out_d    = 1'b0;
        load_err_d      = 1'b0;
        pending_valid_d = pending_valid_q;
        case (state_q)
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d      = COMMIT;
                    write_reg_d  = rd_q;
                    write_data_d = load_extract(mem_rdata, funct3_q, addr_lo_q);
                    reg_wr_out_d = reg_write_q && (rd_q != 5'd0);
                end else begin
                    state_d = WAIT_LOAD;
                end
            end
            default: begin
                if (accept_s) begin
                    reg_write_d  = in_reg_write;
                    rd_d         = in_rd;
                    wb_sel_d     = in_wb_sel;
                    funct3_d     = in_funct3;
                    addr_lo_d    = in_addr_lo;
                    alu_result_d = in_alu_result;
                    pc_plus4_d   = in_pc_plus4;
                    if (in_wb_sel != 2'b01) begin
                        state_d         = COMMIT;
                        write_reg_d     = in_rd;
                        write_data_d    = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                        reg_wr_out_d    = will_write_s;
                        pending_valid_d = will_write_s;
                    end else if (load_bad(in_funct3, in_addr_lo)) begin
                        // Faulting load still occupies a COMMIT slot but writes nothing.
                        state_d         = COMMIT;
                        write_reg_d     = in_rd;
                        load_err_d      = 1'b1;
                        pending_valid_d = 1'b0;
                    end else begin
                        state_d         = WAIT_LOAD;
                        pending_valid_d = will_write_s;
                    end
                end else begin
                    state_d         = IDLE;
                    pending_valid_d = 1'b0;
                end
            end
        endcase
        in_ready_d = (state_d != WAIT_LOAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            reg_write_q     <= 1'b0;
            rd_q            <= 5'd0;
            wb_sel_q        <= 2'b00;
            funct3_q        <= 3'b000;
            addr_lo_q       <= 2'b00;
            alu_result_q    <= 32'h0000_0000;
            pc_plus4_q      <= 32'h0000_0000;
            write_reg_q     <= 5'd0;
            write_data_q    <= 32'h0000_0000;
            reg_wr_out_q    <= 1'b0;
            load_err_q      <= 1'b0;
            pending_valid_q <= 1'b0;
            in_ready_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            reg_write_q     <= reg_write_d;
            rd_q            <= rd_d;
            wb_sel_q        <= wb_sel_d;
            funct3_q        <= funct3_d;
            addr_lo_q       <= addr_lo_d;
            alu_result_q    <= alu_result_d;
            pc_plus4_q      <= pc_plus4_d;
            write_reg_q     <= write_reg_d;
            write_data_q    <= write_data_d;
            reg_wr_out_q    <= reg_wr_out_d;
            load_err_q      <= load_err_d;
            pending_valid_q <= pending_valid_d;
            in_ready_q      <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign regWrite      = reg_wr_out_q;
    assign writeReg      = write_reg_q;
    assign writeData     = write_data_q;
    assign pending_valid = pending_valid_q;
    assign pending_rd    = rd_q;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected commits go into a scoreboard queue and are
// popped by a negedge monitor whenever the DUT writes or flags a load error.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        pending_valid;
    logic [4:0]  pending_rd;
    logic        load_err;

    typedef struct {
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    wb_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .pending_valid(pending_valid), .pending_rd(pending_rd), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.err  = err;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3, input logic [1:0] lo);
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc_plus4   = pc;
        in_funct3     = f3;
        in_addr_lo    = lo;
    endtask

    // Legal load: accept, wait 'gap' idle cycles, then deliver the word.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] word, input logic [31:0] exp, input int gap);
        drive(1'b1, rd, 2'b01, 32'hDEAD_0000, 32'h0000_0000, f3, lo);
        push(1'b0, rd, exp);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            check("wait_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        check("load_data", writeData, exp);
    endtask

    // Scoreboard monitor: every write or load error must match the oldest expectation.
    always @(negedge clk) begin
        if (regWrite === 1'b1 || load_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_commit", {27'd0, writeReg}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_err", {31'd0, load_err}, {31'd0, e.err});
                check("sb_wr", {31'd0, regWrite}, {31'd0, ~e.err});
                check("sb_rd", {27'd0, writeReg}, {27'd0, e.rd});
                if (!e.err) check("sb_data", writeData, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        drive(1'b1, 5'd3, 2'b00, 32'hCAFE_F00D, 32'h0, 3'b000, 2'b00);
        tick();
        tick();
        in_valid = 1'b0;
        reset = 1'b0;
        check("rst_regWrite", {31'd0, regWrite}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_writeData", writeData, 32'd0);
        check("rst_pending", {26'd0, pending_valid, pending_rd}, 32'd0);

        // mem_rvalid in IDLE must be ignored
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;

        // back-to-back ALU ops
        drive(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'b000, 2'b00);
        push(1'b0, 5'd5, 32'h1234_5678);
        tick();
        check("alu1_regWrite", {31'd0, regWrite}, 32'd1);
        check("alu1_data", writeData, 32'h1234_5678);
        drive(1'b1, 5'd6, 2'b11, 32'hA5A5_0001, 32'h0, 3'b000, 2'b00);
        push(1'b0, 5'd6, 32'hA5A5_0001);
        tick();
        check("alu2_writeReg", {27'd0, writeReg}, 32'd6);
        in_valid = 1'b0;
        tick();
        check("idle_regWrite", {31'd0, regWrite}, 32'd0);
        check("hold_data", writeData, 32'hA5A5_0001);

        // lb with two-cycle memory gap
        drive(1'b1, 5'd7, 2'b01, 32'h0, 32'h0, 3'b000, 2'b11);
        push(1'b0, 5'd7, 32'hFFFF_FF80);
        tick();
        in_valid = 1'b0;
        check("lb_in_ready0", {31'd0, in_ready}, 32'd0);
        check("lb_pending", {26'd0, pending_valid, pending_rd}, {26'd0, 1'b1, 5'd7});
        tick();
        check("lb_in_ready1", {31'd0, in_ready}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_0000;
        tick();
        mem_rvalid = 1'b0;
        check("lb_regWrite", {31'd0, regWrite}, 32'd1);
        check("lb_data", writeData, 32'hFFFF_FF80);
        tick();

        do_load(5'd8,  3'b101, 2'b10, 32'hBEEF_1234, 32'h0000_BEEF, 1);
        do_load(5'd9,  3'b001, 2'b10, 32'hBEEF_1234, 32'hFFFF_BEEF, 0);
        do_load(5'd10, 3'b100, 2'b01, 32'h1234_F6A5, 32'h0000_00F6, 2);
        do_load(5'd11, 3'b000, 2'b00, 32'h1234_F6A5, 32'hFFFF_FFA5, 0);
        do_load(5'd12, 3'b010, 2'b00, 32'h1234_F6A5, 32'h1234_F6A5, 1);
        do_load(5'd13, 3'b001, 2'b00, 32'h0000_7FFF, 32'h0000_7FFF, 0);
        in_valid = 1'b0;
        tick();

        // rd=0 link write commits without writing
        drive(1'b1, 5'd0, 2'b10, 32'h0, 32'h0000_0104, 3'b000, 2'b00);
        tick();
        in_valid = 1'b0;
        check("rd0_writeData", writeData, 32'h0000_0104);
        check("rd0_writeReg", {27'd0, writeReg}, 32'd0);
        check("rd0_regWrite", {31'd0, regWrite}, 32'd0);
        check("rd0_pending", {31'd0, pending_valid}, 32'd0);
        tick();

        // misaligned lw and illegal funct3
        drive(1'b1, 5'd14, 2'b01, 32'h0, 32'h0, 3'b010, 2'b01);
        push(1'b1, 5'd14, 32'h0);
        tick();
        in_valid = 1'b0;
        check("lw_mis_err", {31'd0, load_err}, 32'd1);
        check("lw_mis_ready", {31'd0, in_ready}, 32'd1);
        check("lw_mis_pending", {31'd0, pending_valid}, 32'd0);
        tick();
        check("lw_mis_pulse", {31'd0, load_err}, 32'd0);
        drive(1'b1, 5'd15, 2'b01, 32'h0, 32'h0, 3'b011, 2'b00);
        push(1'b1, 5'd15, 32'h0);
        tick();
        drive(1'b1, 5'd16, 2'b01, 32'h0, 32'h0, 3'b101, 2'b11);
        push(1'b1, 5'd16, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();

        // reset while waiting for load data discards the load
        drive(1'b1, 5'd17, 2'b01, 32'h0, 32'h0, 3'b010, 2'b00);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        check("rst_wait_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wait_out", {24'd0, regWrite, load_err, pending_valid, writeReg}, 32'd0);
        check("rst_wait_prd", {27'd0, pending_rd}, 32'd0);
        check("rst_wait_data", writeData, 32'd0);
        tick();
        tick();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-003 in_valid  input  1  MEM stage presents an instruction.
REQ-004 in_ready  output  1  wb_stage can accept; equals (state != WAIT_LOAD).
REQ-005 in_reg_write  input  1  instruction writes rd.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
REQ-008 in_alu_result  input  32  ALU result.
REQ-009 in_pc_plus4  input  32  link value.
REQ-010 in_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-011 in_addr_lo  input  2  load address bits [1:0].
REQ-012 mem_rvalid  input  1  load data valid this cycle.
REQ-013 mem_rdata  input  32  aligned 32-bit word from data memory.
REQ-014 regWrite  output  1  register-file write enable.
REQ-015 writeReg  output  5  register-file write index.
REQ-016 writeData  output  32  register-file write data.
REQ-017 pending_valid  output  1  an accepted instruction will still write a register.
REQ-018 pending_rd  output  5  destination of that pending write.
REQ-019 load_err  output  1  one-cycle pulse: misaligned or illegal load.

Function
REQ-020 States SHALL be IDLE, WAIT_LOAD, COMMIT; acceptance = in_valid && in_ready.
REQ-021 On acceptance, wb_stage SHALL latch reg_write, rd, wb_sel, funct3, addr_lo, alu_result, pc_plus4.
REQ-022 Accept of non-load SHALL go to COMMIT with writeData = alu_result (00/11) or pc_plus4 (10); latency one cycle: regWrite high on the cycle after acceptance.
REQ-023 Accept of legal, aligned load SHALL go to WAIT_LOAD; in_ready low while in WAIT_LOAD.
REQ-024 In WAIT_LOAD, mem_rvalid high SHALL register the extracted load value into writeData and go to COMMIT; mem_rvalid low SHALL hold state.
REQ-025 Extraction: lb/lbu select byte addr_lo (byte 0 = bits 7:0), lh/lhu select halfword addr_lo[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
REQ-026 Misaligned load (lh/lhu with addr_lo[0]=1, lw with addr_lo!=0) or illegal funct3 (011,110,111) SHALL skip WAIT_LOAD, go to COMMIT, pulse load_err during that COMMIT cycle, and suppress regWrite.
REQ-027 regWrite SHALL equal (state==COMMIT) && latched reg_write && latched rd!=0 && !load_err; writeReg = latched rd whenever state==COMMIT.
REQ-028 COMMIT SHALL last exactly one cycle; with simultaneous acceptance it SHALL transition per REQ-022/023/026, else to IDLE, enabling one instruction per cycle for non-loads.
REQ-029 mem_rvalid in IDLE or COMMIT SHALL be ignored.
REQ-030 pending_valid SHALL equal (state!=IDLE) && latched reg_write && latched rd!=0 && no load_err condition; pending_rd = latched rd.
REQ-031 writeReg/writeData SHALL hold their last values outside COMMIT.

Reset
REQ-032 reset high SHALL force next state IDLE; regWrite=0, writeReg=0, writeData=0, pending_valid=0, pending_rd=0, load_err=0, in_ready=1.
REQ-033 reset during WAIT_LOAD or COMMIT SHALL discard the instruction; no register write results, even if mem_rvalid arrives the same or a later cycle.
REQ-034 in_valid during reset SHALL not be accepted.

Verification
REQ-035 ALU: accept rd=5, wb_sel=00, alu=0x12345678, reg_write=1 -> next cycle regWrite=1, writeReg=5, writeData=0x12345678; back-to-back second ALU op commits the following cycle.
REQ-036 lb: rd=7, addr_lo=3, mem_rvalid 2 cycles after accept with rdata=0x80FF0000 -> in_ready=0 for 2 cycles, pending_valid=1/pending_rd=7, then writeData=0xFFFFFF80, regWrite=1.
REQ-037 lhu: addr_lo=2, rdata=0xBEEF1234 -> writeData=0x0000BEEF; lh same -> 0xFFFFBEEF.
REQ-038 rd=0, wb_sel=10, pc_plus4=0x104 -> COMMIT occurs, regWrite=0, pending_valid=0.
REQ-039 lw addr_lo=1 -> next cycle load_err=1 for one cycle, regWrite=0, in_ready stays 1.
REQ-040 reset asserted one cycle in WAIT_LOAD, then mem_rvalid=1 -> state IDLE, regWrite never asserted, all outputs at reset values.
